column_approx_mult_seq: RTL and testbench

//  Iterative shift-add multiplier with column truncation. Unsigned, parametrised width,

---
 rtl/column_approx_mult_seq_if.sv | 26 ++
 rtl/column_approx_mult_seq.sv | 106 ++++++++++
 tb/tb_column_approx_mult_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/column_approx_mult_seq_if.sv
// Operand/result handshake bundle for the sequential column-truncated multiplier.
// The master drives operands and out_ready; the slave returns in_ready, out_valid and z.
interface column_approx_mult_seq_if #(
  parameter int WIDTH = 8
);
  localparam int TW = $clog2(WIDTH + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [TW-1:0]        theta;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;

  modport master (
    output in_valid, x, y, theta, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, x, y, theta, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/column_approx_mult_seq.sv
// Iterative shift-add unsigned multiplier, one partial-product row per cycle, with the
// low max(theta-row,0) bits of x cleared in each row (theta=0 gives the exact product).
module column_approx_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  column_approx_mult_seq_if.slave   bus
);
  localparam int TW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   z_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic [TW-1:0]        theta_q;

  logic [TW-1:0]        theta_d;
  logic [WIDTH-1:0]     row_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 last_d;

  // Row r of the array: x with its low max(theta-r,0) bits cleared, gated by y[r].
  function automatic logic [WIDTH-1:0] trunc_row(input logic [WIDTH-1:0] xv,
                                                 input logic            yb,
                                                 input logic [TW-1:0]   th,
                                                 input logic [CW-1:0]   r);
    int              k;
    logic [WIDTH:0]  low;
    k = int'(th) - int'(r);
    if (k < 0) k = 0;
    low = (ONE << k) - ONE;
    return xv & ~low[WIDTH-1:0] & {WIDTH{yb}};
  endfunction

  always_comb begin
    theta_d = (bus.theta > TW'(WIDTH)) ? TW'(WIDTH) : bus.theta;
    row_d   = trunc_row(x_q, y_q[cnt_q], theta_q, cnt_q);
    acc_d   = acc_q + ({{WIDTH{1'b0}}, row_d} << cnt_q);
    last_d  = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      theta_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.x;
            y_q        <= bus.y;
            theta_q    <= theta_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          if (last_d) begin
            cnt_q       <= '0;
            z_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // z is left holding the result after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
endmodule

// File: tb/tb_column_approx_mult_seq.sv
// Self-checking bench for column_approx_mult_seq (WIDTH=8): directed vectors, handshake
// corner cases and randomized operations checked against a row-formula reference model.
module tb_column_approx_mult_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  column_approx_mult_seq_if #(.WIDTH(W)) bus ();

  column_approx_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: sum over rows i with y[i]=1 of (x with low max(theta-i,0) bits zeroed) * 2^i.
  function automatic logic [15:0] model(input logic [7:0] xa, input logic [7:0] ya,
                                        input logic [3:0] ta);
    int     th;
    longint sum;
    th  = (int'(ta) > W) ? W : int'(ta);
    sum = 0;
    for (int i = 0; i < W; i++) begin
      if (ya[i]) begin
        int k;
        k = (th - i > 0) ? th - i : 0;
        sum += longint'((int'(xa) >> k) << k) << i;
      end
    end
    return 16'(sum);
  endfunction

  task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic [3:0] ta,
                        input int hold, output logic [15:0] zr, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      tests_run++; fails++;
      $display("FAIL run_op_in_ready_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.x = xa; bus.y = ya; bus.theta = ta; bus.out_ready = 1'b0;
    @(negedge clk);
    // Scramble the inputs while busy: the latched copies must be used.
    bus.in_valid = 1'b0; bus.x = 8'($urandom); bus.y = 8'($urandom); bus.theta = 4'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.out_valid) begin
      tests_run++; fails++;
      $display("FAIL run_op_out_valid_timeout: out_valid=%0b required 1", bus.out_valid);
    end
    repeat (hold) @(negedge clk);
    zr = bus.z;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    tests_run++;
    if (bus.z !== 16'd0) begin fails++; $display("FAIL reset_z: got %0d want 0", bus.z); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0]  xs [5] = '{8'd255, 8'd255, 8'd3, 8'd3,   8'd255};
    logic [7:0]  ys [5] = '{8'd255, 8'd255, 8'd1, 8'd128, 8'd1};
    logic [3:0]  ts [5] = '{4'd0,   4'd7,   4'd7, 4'd7,   4'd15};
    logic [15:0] es [5] = '{16'd65025, 16'd64256, 16'd0, 16'd384, 16'd0};
    logic [15:0] zr;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(xs[i], ys[i], ts[i], 0, zr, lat);
      tests_run++;
      if (zr !== es[i]) begin fails++; $display("FAIL vector%0d_z: got %0d want %0d", i, zr, es[i]); end
      tests_run++;
      if (lat !== W) begin fails++; $display("FAIL vector%0d_latency: got %0d edges want %0d", i, lat, W); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] zr, z0;
    int lat;
    run_op(8'd200, 8'd77, 4'd3, 0, zr, lat);
    bus.in_valid = 1'b1; bus.x = 8'd13; bus.y = 8'd17; bus.theta = 4'd0; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    z0 = bus.z;
    tests_run++;
    if (z0 !== 16'd221) begin fails++; $display("FAIL bp_z: got %0d want 221", z0); end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1; bus.x = 8'd1; bus.y = 8'd1;
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.z !== z0) begin
        fails++;
        $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b z=%0d want 1/0/%0d",
                 c, bus.out_valid, bus.in_ready, bus.z, z0);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.z !== z0) begin
      fails++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b z=%0d want 0/1/%0d",
               bus.out_valid, bus.in_ready, bus.z, z0);
    end
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_no_queue: out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] zr;
    int lat;
    bus.in_valid = 1'b1; bus.x = 8'd255; bus.y = 8'd255; bus.theta = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.z !== 16'd0) begin
      fails++;
      $display("FAIL midop_reset: in_ready=%0b out_valid=%0b z=%0d want 1/0/0",
               bus.in_ready, bus.out_valid, bus.z);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd7, 8'd9, 4'd0, 0, zr, lat);
    tests_run++;
    if (zr !== 16'd63) begin fails++; $display("FAIL midop_followup_z: got %0d want 63", zr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq[$];
    int          acc_t[$];
    int          spacing;
    logic [15:0] e;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (bus.out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        tests_run++;
        if (bus.z !== e) begin fails++; $display("FAIL b2b_z: got %0d want %0d", bus.z, e); end
      end
      bus.in_valid = (t < 35);
      bus.x = 8'($urandom); bus.y = 8'($urandom); bus.theta = 4'($urandom_range(0, 9));
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.x, bus.y, bus.theta));
        acc_t.push_back(t);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tests_run++;
    if (acc_t.size() < 3 || expq.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: accepts=%0d pending=%0d want >=3/0", acc_t.size(), expq.size());
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      spacing = acc_t[i] - acc_t[i-1];
      tests_run++;
      if (spacing != W + 2) begin fails++; $display("FAIL b2b_spacing: got %0d want %0d", spacing, W + 2); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  xa, ya;
    logic [3:0]  ta;
    logic [15:0] zr, e;
    int          lat, sel;
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 9);
      xa  = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
      sel = $urandom_range(0, 9);
      ya  = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
      ta  = 4'($urandom_range(0, 15));
      e   = model(xa, ya, ta);
      run_op(xa, ya, ta, $urandom_range(0, 2), zr, lat);
      tests_run++;
      if (zr !== e || lat != W) begin
        fails++;
        $display("FAIL random x=%0d y=%0d theta=%0d: z=%0d lat=%0d want z=%0d lat=%0d",
                 xa, ya, ta, zr, lat, e, W);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.theta = '0; bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
